// File: rtl/data_mem_responder.sv
// Byte-addressed data RAM answering the core's memory port with four big-endian lanes.
// After halt it streams the whole image out over a valid/ready dump port.
module data_mem_responder #(
  parameter int unsigned ADDR_BITS = 16,
  parameter bit          DUMP_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_data_in  [0:3],
  input  logic        mem_write_en,
  output logic [7:0]  mem_data_out [0:3],
  input  logic        halted,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_addr,
  output logic [31:0] dump_data,
  output logic        dump_done,
  output logic        misaligned_err,
  output logic [31:0] write_count
);

  localparam int unsigned Bytes = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {StRun, StDump, StDone} state_e;

  state_e               state_q, state_d;
  logic [7:0]           mem [Bytes];
  logic [ADDR_BITS-1:0] idx;
  logic [ADDR_BITS-1:0] dump_ptr_q, dump_ptr_d;
  logic                 write_fire;
  logic                 dump_last;
  logic                 misaligned_q;
  logic [31:0]          count_q;
  logic                 unused_addr;

  // Address bits above the decoded range alias onto the same bytes.
  assign unused_addr = ^mem_addr[31:ADDR_BITS];

  assign idx        = mem_addr[ADDR_BITS-1:0];
  assign write_fire = mem_write_en && !halted && (state_q == StRun);
  assign dump_last  = &dump_ptr_q[ADDR_BITS-1:2];

  // Lane offsets wrap naturally at the ADDR_BITS width.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      mem_data_out[k] = mem[idx + ADDR_BITS'(k)];
    end
  end

  assign dump_data = {mem[dump_ptr_q],
                      mem[dump_ptr_q + ADDR_BITS'(1)],
                      mem[dump_ptr_q + ADDR_BITS'(2)],
                      mem[dump_ptr_q + ADDR_BITS'(3)]};

  // Contents are deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (write_fire) begin
      for (int k = 0; k < 4; k++) begin
        mem[idx + ADDR_BITS'(k)] <= mem_data_in[k];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    dump_ptr_d = dump_ptr_q;
    case (state_q)
      StRun: begin
        if (halted) state_d = DUMP_EN ? StDump : StDone;
      end
      StDump: begin
        if (dump_ready) begin
          if (dump_last) state_d = StDone;
          else           dump_ptr_d = dump_ptr_q + ADDR_BITS'(4);
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= StRun;
      dump_ptr_q   <= '0;
      misaligned_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q    <= state_d;
      dump_ptr_q <= dump_ptr_d;
      if (write_fire && (mem_addr[1:0] != 2'b00)) misaligned_q <= 1'b1;
      if (write_fire && (count_q != 32'hFFFF_FFFF)) count_q <= count_q + 32'd1;
    end
  end

  assign dump_valid     = (state_q == StDump);
  assign dump_done      = (state_q == StDone);
  assign dump_addr      = 32'(dump_ptr_q);
  assign misaligned_err = misaligned_q;
  assign write_count    = count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-array model of the RAM,
// using 256-byte instances with and without the end-of-test dump.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in  [0:3];
  logic        mem_write_en;
  logic [7:0]  mem_data_out [0:3];
  logic        halted;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_addr;
  logic [31:0] dump_data;
  logic        dump_done;
  logic        misaligned_err;
  logic [31:0] write_count;

  logic        nd_rst_b;
  logic [31:0] nd_addr;
  logic [7:0]  nd_din  [0:3];
  logic [7:0]  nd_dout [0:3];
  logic        nd_halted;
  logic        nd_valid;
  logic [31:0] nd_dump_addr;
  logic [31:0] nd_dump_data;
  logic        nd_done;
  logic        nd_err;
  logic [31:0] nd_count;
  logic        nd_seen_valid = 1'b0;

  logic [7:0]  ref_mem [256];
  int unsigned ref_count;
  logic        ref_err;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_BITS(8), .DUMP_EN(1'b1)) u_dut (
    .clk(clk), .rst_b(rst_b), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .mem_data_out(mem_data_out), .halted(halted),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_done(dump_done), .misaligned_err(misaligned_err),
    .write_count(write_count)
  );

  data_mem_responder #(.ADDR_BITS(8), .DUMP_EN(1'b0)) u_nodump (
    .clk(clk), .rst_b(nd_rst_b), .mem_addr(nd_addr), .mem_data_in(nd_din),
    .mem_write_en(1'b0), .mem_data_out(nd_dout), .halted(nd_halted),
    .dump_valid(nd_valid), .dump_ready(1'b1), .dump_addr(nd_dump_addr),
    .dump_data(nd_dump_data), .dump_done(nd_done), .misaligned_err(nd_err),
    .write_count(nd_count)
  );

  always @(posedge clk) if (nd_valid) nd_seen_valid <= 1'b1;

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    return {ref_mem[a], ref_mem[a + 8'd1], ref_mem[a + 8'd2], ref_mem[a + 8'd3]};
  endfunction

  function automatic logic [31:0] out_word();
    return {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
  endfunction

  task automatic drive_data(input logic [31:0] d);
    for (int k = 0; k < 4; k++) mem_data_in[k] = d[31-8*k -: 8];
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) ref_mem[8'(a[7:0] + 8'(k))] = d[31-8*k -: 8];
    ref_count++;
    if (a[1:0] != 2'b00) ref_err = 1'b1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_addr = a;
    drive_data(d);
    mem_write_en = 1'b1;
    @(negedge clk);
    mem_write_en = 1'b0;
    model_write(a, d);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({dump_valid, dump_addr, dump_done, misaligned_err, write_count} !== 67'd0)
      $display("FAIL reset: valid=%b addr=%h done=%b err=%b count=%0d, want all zero",
               dump_valid, dump_addr, dump_done, misaligned_err, write_count);
    else n_pass++;
    @(negedge clk);
    rst_b    = 1'b1;
    nd_rst_b = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 64; i++) do_write({$urandom_range(0, 32'hFF_FFFF), 8'(4 * i)}, $urandom);
    n_checks++;
    if (write_count !== ref_count || misaligned_err !== 1'b0)
      $display("FAIL fill: count=%0d err=%b, want count=%0d err=0",
               write_count, misaligned_err, ref_count);
    else n_pass++;
  endtask

  task automatic test_write_read();
    logic [31:0] old;
    old = ref_word(8'h10);
    @(negedge clk);
    mem_addr = 32'h10;
    drive_data(32'h1234_5678);
    mem_write_en = 1'b1;
    #1;
    n_checks++;
    if (out_word() !== old) $display("FAIL same_cycle_read: got %h want %h", out_word(), old);
    else n_pass++;
    @(negedge clk);
    mem_write_en = 1'b0;
    model_write(32'h10, 32'h1234_5678);
    n_checks++;
    if (out_word() !== 32'h1234_5678 || write_count !== 32'd65)
      $display("FAIL write_read: data=%h count=%0d, want 12345678 count=65",
               out_word(), write_count);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    n_checks++;
    if (misaligned_err !== 1'b0) $display("FAIL err_before: got %b want 0", misaligned_err);
    else n_pass++;
    do_write(32'h12, 32'hAABB_CCDD);
    n_checks++;
    if (out_word() !== 32'hAABB_CCDD || misaligned_err !== 1'b1)
      $display("FAIL misaligned: data=%h err=%b, want aabbccdd err=1", out_word(), misaligned_err);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_addr = $urandom;
      #1;
      n_checks++;
      if (misaligned_err !== 1'b1 || out_word() !== ref_word(mem_addr[7:0]))
        $display("FAIL err_sticky[%0d]: err=%b data=%h, want err=1 data=%h",
                 i, misaligned_err, out_word(), ref_word(mem_addr[7:0]));
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] hi_word;
    do_write(32'hFE, 32'h0102_0304);
    n_checks++;
    if (out_word() !== 32'h0102_0304) $display("FAIL wrap_fe: got %h want 01020304", out_word());
    else n_pass++;
    mem_addr = 32'h0;
    #1;
    n_checks++;
    if (mem_data_out[0] !== 8'h03 || mem_data_out[1] !== 8'h04)
      $display("FAIL wrap_00: got %h want 0304....", out_word());
    else n_pass++;
    mem_addr = 32'h0001_0004;
    #1;
    hi_word = out_word();
    mem_addr = 32'h4;
    #1;
    n_checks++;
    if (hi_word !== out_word() || hi_word !== ref_word(8'h04))
      $display("FAIL alias: @10004=%h @4=%h want %h", hi_word, out_word(), ref_word(8'h04));
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      mem_addr = $urandom;
      d = $urandom;
      drive_data(d);
      mem_write_en = 1'($urandom);
      #1;
      n_checks++;
      if (out_word() !== ref_word(mem_addr[7:0]))
        $display("FAIL rand_read[%0d]: addr=%h got %h want %h",
                 i, mem_addr, out_word(), ref_word(mem_addr[7:0]));
      else n_pass++;
      if (mem_write_en) model_write(mem_addr, d);
    end
    @(negedge clk);
    mem_write_en = 1'b0;
    n_checks++;
    if (write_count !== ref_count || misaligned_err !== ref_err)
      $display("FAIL rand_stats: count=%0d err=%b want %0d %b",
               write_count, misaligned_err, ref_count, ref_err);
    else n_pass++;
  endtask

  task automatic test_dump();
    @(negedge clk);
    mem_addr = 32'h40;
    drive_data(~ref_word(8'h40));
    mem_write_en = 1'b1;
    halted       = 1'b1;
    @(negedge clk);
    mem_write_en = 1'b0;
    n_checks++;
    if (write_count !== ref_count || out_word() !== ref_word(8'h40))
      $display("FAIL halt_write: count=%0d data=%h want %0d %h",
               write_count, out_word(), ref_count, ref_word(8'h40));
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dump_valid !== 1'b1 || dump_addr !== 32'h0 || dump_data !== ref_word(8'h0))
        $display("FAIL dump_stall[%0d]: valid=%b addr=%h data=%h want 1 0 %h",
                 i, dump_valid, dump_addr, dump_data, ref_word(8'h0));
      else n_pass++;
      @(negedge clk);
    end
    dump_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (dump_valid !== 1'b1 || dump_addr !== 32'(4 * i) || dump_data !== ref_word(8'(4 * i)))
        $display("FAIL dump[%0d]: valid=%b addr=%h data=%h want 1 %h %h", i, dump_valid,
                 dump_addr, dump_data, 32'(4 * i), ref_word(8'(4 * i)));
      else n_pass++;
      // Dropped halt and a write attempt must both be ignored while dumping.
      if (i == 20) begin
        halted       = 1'b0;
        mem_addr     = 32'h8;
        mem_write_en = 1'b1;
      end
      @(negedge clk);
    end
    dump_ready   = 1'b0;
    mem_write_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dump_done !== 1'b1 || dump_valid !== 1'b0 || write_count !== ref_count)
        $display("FAIL dump_done[%0d]: done=%b valid=%b count=%0d want 1 0 %0d",
                 i, dump_done, dump_valid, write_count, ref_count);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_dump();
    rst_b = 1'b0;
    @(negedge clk);
    rst_b     = 1'b1;
    ref_count = 0;
    ref_err   = 1'b0;
    n_checks++;
    if (dump_done !== 1'b0 || write_count !== 32'd0 || misaligned_err !== 1'b0)
      $display("FAIL rerun: done=%b count=%0d err=%b want 0 0 0",
               dump_done, write_count, misaligned_err);
    else n_pass++;
    halted = 1'b1;
    @(negedge clk);
    dump_ready = 1'b1;
    repeat (10) @(negedge clk);
    dump_ready = 1'b0;
    n_checks++;
    if (dump_valid !== 1'b1 || dump_addr !== 32'h28)
      $display("FAIL dump_28: valid=%b addr=%h want 1 00000028", dump_valid, dump_addr);
    else n_pass++;
    #2 rst_b = 1'b0;
    #1;
    n_checks++;
    if (dump_valid !== 1'b0 || dump_addr !== 32'h0 || dump_done !== 1'b0)
      $display("FAIL abort: valid=%b addr=%h done=%b want 0 0 0", dump_valid, dump_addr, dump_done);
    else n_pass++;
    @(negedge clk);
    halted = 1'b0;
    rst_b  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      mem_addr = 32'(4 * i);
      #1;
      n_checks++;
      if (out_word() !== ref_word(8'(4 * i)))
        $display("FAIL preserved[%0d]: got %h want %h", i, out_word(), ref_word(8'(4 * i)));
      else n_pass++;
    end
  endtask

  task automatic test_no_dump();
    @(negedge clk);
    nd_halted = 1'b1;
    #1;
    n_checks++;
    if (nd_done !== 1'b0) $display("FAIL nodump_early: done=%b want 0", nd_done);
    else n_pass++;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (nd_done !== 1'b1 || nd_valid !== 1'b0)
        $display("FAIL nodump[%0d]: done=%b valid=%b want 1 0", i, nd_done, nd_valid);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (nd_seen_valid !== 1'b0) $display("FAIL nodump_valid_seen: got %b want 0", nd_seen_valid);
    else n_pass++;
  endtask

  initial begin
    rst_b        = 1'b0;
    nd_rst_b     = 1'b0;
    mem_addr     = '0;
    mem_write_en = 1'b0;
    halted       = 1'b0;
    dump_ready   = 1'b0;
    nd_addr      = '0;
    nd_halted    = 1'b0;
    ref_count    = 0;
    ref_err      = 1'b0;
    drive_data(32'h0);
    for (int k = 0; k < 4; k++) nd_din[k] = 8'h0;
    test_reset();
    test_fill();
    test_write_read();
    test_misaligned();
    test_wrap();
    test_random();
    test_dump();
    test_reset_mid_dump();
    test_no_dump();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
